// File: rtl/psram_pkg.sv
// psram_pkg: state encoding and default timing shared by the PSRAM
// responder and the PSRAM controller side.
package psram_pkg;

  localparam int PSRAM_AW          = 16;
  localparam int PSRAM_LAT         = 4;
  localparam int PSRAM_HIGH_CYCLES = 2;
  localparam int PSRAM_LOW_CYCLES  = 2;
  localparam int PSRAM_INIT_CYCLES = 16;
  localparam int PSRAM_CW          = 16;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_LOW  = 3'd2,
    ST_RD_HIGH = 3'd3,
    ST_WR_HIGH = 3'd4,
    ST_WR_LOW  = 3'd5
  } psram_state_e;

  // Phase counters count down to zero, so a phase of n cycles loads n-1.
  function automatic logic [PSRAM_CW-1:0] phase_load(input int n);
    return PSRAM_CW'(n - 1);
  endfunction

endpackage

// File: rtl/psram_bram_array.sv
// psram_bram_array: single-port byte-wide store, synchronous read with
// one cycle of latency, read-first on a simultaneous write.
module psram_bram_array #(
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/psram_bram_responder.sv
// psram_bram_responder: answers PSRAM-style strobed byte bursts from a
// block-RAM backing store.
module psram_bram_responder
  import psram_pkg::*;
#(
  parameter int AW          = PSRAM_AW,
  parameter int LAT         = PSRAM_LAT,
  parameter int HIGH_CYCLES = PSRAM_HIGH_CYCLES,
  parameter int LOW_CYCLES  = PSRAM_LOW_CYCLES,
  parameter int INIT_CYCLES = PSRAM_INIT_CYCLES
) (
  input  logic        clk_mem,
  input  logic        rst,
  input  logic        rd,
  input  logic        rend,
  input  logic        we,
  input  logic        wend,
  input  logic [23:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        byte_available,
  output logic        ready_for_next_byte,
  output logic        ready
);

  psram_state_e        state_q;
  logic [PSRAM_CW-1:0] cnt_q;
  logic [AW-1:0]       addr_q;
  logic                stop_q;
  logic                last_q;
  logic                wpend_q;
  logic                ready_q;
  logic                bav_q;
  logic                rfnb_q;
  logic [7:0]          dout_q;
  logic [7:0]          ram_rdata;
  logic                ram_we;
  logic                cnt_done;
  logic                unused_a;

  assign unused_a = ^a[23:AW];
  assign cnt_done = (cnt_q == '0);

  // A byte is committed only on the final WR_LOW edge; reset on that
  // edge must suppress it so an aborted burst leaves memory untouched.
  assign ram_we = !rst && (state_q == ST_WR_LOW)
               && cnt_done && wpend_q;

  psram_bram_array #(
    .AW(AW)
  ) u_array (
    .clk_i  (clk_mem),
    .we_i   (ram_we),
    .addr_i (addr_q),
    .wdata_i(din),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_mem) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      addr_q  <= '0;
      stop_q  <= 1'b0;
      last_q  <= 1'b0;
      wpend_q <= 1'b0;
      ready_q <= 1'b0;
      bav_q   <= 1'b0;
      rfnb_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          if (cnt_q == phase_load(INIT_CYCLES)) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          stop_q  <= 1'b0;
          last_q  <= 1'b0;
          wpend_q <= 1'b0;
          if (we) begin
            addr_q  <= a[AW-1:0];
            ready_q <= 1'b0;
            cnt_q   <= phase_load(LAT);
            state_q <= ST_WR_LOW;
          end else if (rd) begin
            addr_q  <= a[AW-1:0];
            ready_q <= 1'b0;
            cnt_q   <= phase_load(LAT);
            state_q <= ST_RD_LOW;
          end
        end
        ST_RD_LOW: begin
          if (rend) stop_q <= 1'b1;
          if (cnt_done) begin
            state_q <= ST_RD_HIGH;
            bav_q   <= 1'b1;
            dout_q  <= ram_rdata;
            addr_q  <= addr_q + 1'b1;
            // rend seen before this rise makes this the final byte
            last_q  <= stop_q | rend;
            cnt_q   <= phase_load(HIGH_CYCLES);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RD_HIGH: begin
          if (rend) stop_q <= 1'b1;
          if (cnt_done) begin
            bav_q <= 1'b0;
            if (last_q) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_RD_LOW;
              cnt_q   <= phase_load(LOW_CYCLES);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WR_HIGH: begin
          if (wend) stop_q <= 1'b1;
          if (cnt_done) begin
            rfnb_q  <= 1'b0;
            state_q <= ST_WR_LOW;
            cnt_q   <= phase_load(LOW_CYCLES);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WR_LOW: begin
          if (wend) stop_q <= 1'b1;
          if (cnt_done) begin
            if (wpend_q) addr_q <= addr_q + 1'b1;
            if (stop_q | wend) begin
              wpend_q <= 1'b0;
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              wpend_q <= 1'b1;
              rfnb_q  <= 1'b1;
              state_q <= ST_WR_HIGH;
              cnt_q   <= phase_load(HIGH_CYCLES);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign dout                = dout_q;
  assign byte_available      = bav_q;
  assign ready_for_next_byte = rfnb_q;
  assign ready               = ready_q;

endmodule

// File: tb/tb_psram_bram_responder.sv
// tb_psram_bram_responder: strobe-level initiator model, vector table,
// reset corner cases and randomized bursts against a byte-map model.
module tb_psram_bram_responder;

  localparam int LAT  = 4;
  localparam int INIT = 16;

  logic        clk_mem = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic        rend = 1'b0;
  logic        we = 1'b0;
  logic        wend = 1'b0;
  logic [23:0] a = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        byte_available;
  logic        ready_for_next_byte;
  logic        ready;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] got[$];
  logic [7:0] wq[$];
  logic [7:0] ref_mem [int];

  typedef struct {
    bit             wr;
    logic [23:0]    addr;
    int             n;
    bit             end_low;
    bit             both;
    logic [3:0][7:0] b;
  } vec_t;

  vec_t tv[11];

  always #5 clk_mem = ~clk_mem;

  psram_bram_responder dut (
    .clk_mem            (clk_mem),
    .rst                (rst),
    .rd                 (rd),
    .rend               (rend),
    .we                 (we),
    .wend               (wend),
    .a                  (a),
    .din                (din),
    .dout               (dout),
    .byte_available     (byte_available),
    .ready_for_next_byte(ready_for_next_byte),
    .ready              (ready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got hang required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit wr, input logic [23:0] ad,
                              input int n, input bit el, input bit bo,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    vec_t v;
    v.wr = wr; v.addr = ad; v.n = n; v.end_low = el; v.both = bo;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    return v;
  endfunction

  // Called at the negedge on which rst has just been released.
  task automatic init_check();
    int k;
    bit strobe;
    check("rst_ready", ready, 0);
    check("rst_bav", byte_available, 0);
    check("rst_rfnb", ready_for_next_byte, 0);
    check("rst_dout", dout, 0);
    k = 0;
    strobe = 0;
    while (!ready && k < 100) begin
      @(negedge clk_mem);
      k++;
      if (byte_available || ready_for_next_byte) strobe = 1;
    end
    check("init_len", k, INIT);
    check("init_strobes", strobe, 0);
  endtask

  task automatic do_read(input logic [23:0] addr, input int n,
                         input bit end_low);
    int rises, cyc;
    bit prev, seen_rfnb;
    got.delete();
    a = addr;
    rd = 1;
    @(negedge clk_mem);
    rd = 0;
    check("rd_ready_drop", ready, 0);
    rises = 0; prev = 0; cyc = 0; seen_rfnb = 0;
    if (n == 1) rend = 1;
    while (!ready && cyc < 400) begin
      if (byte_available && !prev) begin
        rises++;
        got.push_back(dout);
        if (rises == 1) check("rd_latency", cyc, LAT);
        if (!end_low && rises == n - 1) rend = 1;
      end
      if (end_low && prev && !byte_available && rises == n - 1)
        rend = 1;
      if (ready_for_next_byte) seen_rfnb = 1;
      prev = byte_available;
      @(negedge clk_mem);
      cyc++;
    end
    rend = 0;
    check("rd_end_ready", ready, 1);
    check("rd_rises", rises, n);
    check("rd_no_rfnb", seen_rfnb, 0);
  endtask

  task automatic do_write(input logic [23:0] addr, input int n,
                          input bit end_low, input bit both);
    int rises, cyc;
    bit prev, seen_bav;
    logic [15:0] idx;
    a = addr;
    din = (wq.size() > 0) ? wq[0] : 8'h00;
    we = 1;
    rd = both;
    @(negedge clk_mem);
    we = 0;
    rd = 0;
    check("wr_ready_drop", ready, 0);
    rises = 0; prev = 0; cyc = 0; seen_bav = 0;
    while (!ready && cyc < 400) begin
      if (ready_for_next_byte && !prev) begin
        if (rises == 0) check("wr_latency", cyc, LAT);
        if (rises < wq.size()) din = wq[rises];
        rises++;
        if (!end_low && rises == n) wend = 1;
      end
      if (end_low && prev && !ready_for_next_byte && rises == n)
        wend = 1;
      if (byte_available) seen_bav = 1;
      prev = ready_for_next_byte;
      @(negedge clk_mem);
      cyc++;
    end
    wend = 0;
    check("wr_end_ready", ready, 1);
    check("wr_rises", rises, n);
    check("wr_no_bav", seen_bav, 0);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      idx = addr[15:0] + 16'(i);
      ref_mem[int'(idx)] = wq[i];
    end
  endtask

  task automatic check_model(input logic [23:0] addr);
    logic [15:0] idx;
    for (int j = 0; j < got.size(); j++) begin
      idx = addr[15:0] + 16'(j);
      if (ref_mem.exists(int'(idx)))
        check($sformatf("model_%0h", idx), got[j], ref_mem[int'(idx)]);
    end
  endtask

  initial begin
    int k, rises;
    bit prev;
    logic [23:0] ad;
    int n;

    tv[0]  = mk(1, 24'h000100, 4, 0, 0, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    tv[1]  = mk(0, 24'h000100, 4, 0, 0, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    tv[2]  = mk(0, 24'h000100, 4, 1, 0, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    tv[3]  = mk(1, 24'h00FFFE, 4, 1, 0, 8'h11, 8'h22, 8'h33, 8'h44);
    tv[4]  = mk(0, 24'h00FFFE, 4, 0, 0, 8'h11, 8'h22, 8'h33, 8'h44);
    tv[5]  = mk(1, 24'h5A0200, 2, 0, 0, 8'hC3, 8'h3C, 8'h00, 8'h00);
    tv[6]  = mk(0, 24'h000200, 2, 1, 0, 8'hC3, 8'h3C, 8'h00, 8'h00);
    tv[7]  = mk(0, 24'h000101, 1, 1, 0, 8'hAD, 8'h00, 8'h00, 8'h00);
    tv[8]  = mk(0, 24'h000101, 1, 0, 0, 8'hAD, 8'h00, 8'h00, 8'h00);
    tv[9]  = mk(1, 24'h000300, 1, 0, 1, 8'h5A, 8'h00, 8'h00, 8'h00);
    tv[10] = mk(0, 24'h000300, 1, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h00);

    repeat (3) @(negedge clk_mem);
    rst = 0;
    init_check();

    for (int i = 0; i < 11; i++) begin
      if (tv[i].wr) begin
        wq.delete();
        for (int j = 0; j < tv[i].n; j++) wq.push_back(tv[i].b[j]);
        do_write(tv[i].addr, tv[i].n, tv[i].end_low, tv[i].both);
      end else begin
        do_read(tv[i].addr, tv[i].n, tv[i].end_low);
        for (int j = 0; j < tv[i].n && j < got.size(); j++)
          check($sformatf("vec%0d_b%0d", i, j), got[j], tv[i].b[j]);
      end
    end

    // Reset in the middle of a read burst after two bytes.
    a = 24'h000100;
    rd = 1;
    @(negedge clk_mem);
    rd = 0;
    rises = 0; prev = 0; k = 0;
    while (rises < 2 && k < 200) begin
      @(negedge clk_mem);
      k++;
      if (byte_available && !prev) rises++;
      prev = byte_available;
    end
    check("midrd_rises", rises, 2);
    check("midrd_dout", dout, 8'hAD);
    rst = 1;
    @(posedge clk_mem);
    #1;
    check("midrd_ready0", ready, 0);
    check("midrd_bav0", byte_available, 0);
    check("midrd_rfnb0", ready_for_next_byte, 0);
    check("midrd_dout0", dout, 0);
    @(negedge clk_mem);
    rst = 0;
    init_check();
    do_read(24'h000100, 4, 0);
    for (int j = 0; j < 4 && j < got.size(); j++)
      check($sformatf("postrst_b%0d", j), got[j], tv[0].b[j]);

    // Reset on the very edge that would commit a write byte.
    a = 24'h000101;
    din = 8'h00;
    we = 1;
    @(negedge clk_mem);
    we = 0;
    prev = 0; k = 0;
    while (k < 200) begin
      @(negedge clk_mem);
      k++;
      if (ready_for_next_byte && !prev) break;
      prev = ready_for_next_byte;
    end
    check("midwr_rise", ready_for_next_byte, 1);
    din = 8'h77;
    while (ready_for_next_byte && k < 200) begin
      @(negedge clk_mem);
      k++;
    end
    @(negedge clk_mem);
    rst = 1;
    @(negedge clk_mem);
    rst = 0;
    init_check();
    do_read(24'h000101, 1, 0);
    if (got.size() > 0) check("midwr_kept", got[0], 8'hAD);

    // Randomized write/read pairs around a low window and the wrap point.
    for (int it = 0; it < 12; it++) begin
      ad[15:0] = ($urandom_range(0, 1) ? 16'hFFF8 : 16'h0400)
               + 16'($urandom_range(0, 15));
      ad[23:16] = 8'($urandom);
      n = $urandom_range(1, 6);
      wq.delete();
      for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
      do_write(ad, n, 1'($urandom_range(0, 1)), 1'b0);
      ad[15:0] = ad[15:0] + 16'($urandom_range(0, 3)) - 16'd1;
      ad[23:16] = 8'($urandom);
      n = $urandom_range(1, 6);
      do_read(ad, n, 1'($urandom_range(0, 1)));
      check_model(ad);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
